bp_me_mem_cmd_arbiter: RTL

- Shares one memory command/response port between num_req_p requesters (e.g. I$ and D$ CCEs in a multi-cache testbench or tile).
- Round-robin arbitration on mem_cmd, with grant locking until the downstream yumi.
- Records the granted requester ID in an in-order tag FIFO and steers each mem_resp back to its owner.
- Memory returns responses in command order.

---
 rtl/bp_me_mem_cmd_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Purpose: round-robin share of one memory cmd/resp port among num_req_p requesters, in-order resp steering.
// Latency: zero-cycle combinational grant; responses steered combinationally from the tag FIFO head.
// Backpressure: grant locked until mem_cmd_yumi_i; no grants while max_outstanding_p in flight; resp waits on owner ready.
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int mem_msg_width_p   = 128,
  parameter int max_outstanding_p = 4,
  localparam int id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cnt_width_lp     = ((max_outstanding_p + 1) > 1) ? $clog2(max_outstanding_p + 1) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,

  input  logic [num_req_p-1:0]                 mem_cmd_v_i,
  input  logic [num_req_p*mem_msg_width_p-1:0] mem_cmd_i,
  output logic [num_req_p-1:0]                 mem_cmd_yumi_o,

  output logic                                 mem_cmd_v_o,
  output logic [mem_msg_width_p-1:0]           mem_cmd_o,
  input  logic                                 mem_cmd_yumi_i,

  input  logic                                 mem_resp_v_i,
  input  logic [mem_msg_width_p-1:0]           mem_resp_i,
  output logic                                 mem_resp_ready_o,

  output logic [num_req_p-1:0]                 mem_resp_v_o,
  output logic [mem_msg_width_p-1:0]           mem_resp_o,
  input  logic [num_req_p-1:0]                 mem_resp_ready_i,

  output logic [cnt_width_lp-1:0]              outstanding_o
);

  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  typedef logic [id_width_lp-1:0]  id_t;
  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [cnt_width_lp-1:0] cnt_t;

  // State
  id_t  last_q, last_d;
  logic lock_v_q, lock_v_d;
  id_t  lock_id_q, lock_id_d;
  cnt_t cnt_q, cnt_d;
  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  id_t  tag_mem_q [max_outstanding_p];

  // Per-requester command slices
  logic [mem_msg_width_p-1:0] cmd_slices [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_slice
    assign cmd_slices[g] = mem_cmd_i[g*mem_msg_width_p +: mem_msg_width_p];
  end

  logic full, empty;
  logic push, pop;
  logic cmd_v_raw;
  id_t  winner_id, grant_id, head_id;

  assign full  = (cnt_q == cnt_t'(max_outstanding_p));
  assign empty = (cnt_q == '0);

  // Round-robin search from last_q+1; scanning farthest-first lets the nearest valid requester win
  always_comb begin
    winner_id = last_q;
    for (int k = num_req_p; k >= 1; k--) begin
      if (mem_cmd_v_i[id_t'((int'(last_q) + k) % num_req_p)]) begin
        winner_id = id_t'((int'(last_q) + k) % num_req_p);
      end
    end
  end

  assign grant_id    = lock_v_q ? lock_id_q : winner_id;
  assign cmd_v_raw   = lock_v_q ? mem_cmd_v_i[lock_id_q] : (|mem_cmd_v_i);
  assign mem_cmd_v_o = cmd_v_raw & ~full & ~reset_i;
  assign mem_cmd_o   = cmd_slices[grant_id];
  assign push        = mem_cmd_v_o & mem_cmd_yumi_i;

  // Acknowledge only the granted requester on a downstream accept
  always_comb begin
    mem_cmd_yumi_o = '0;
    if (push) begin
      mem_cmd_yumi_o[grant_id] = 1'b1;
    end
  end

  // Response steering to the oldest outstanding owner
  assign head_id          = tag_mem_q[rptr_q];
  assign mem_resp_ready_o = ~empty & mem_resp_ready_i[head_id] & ~reset_i;
  assign mem_resp_o       = mem_resp_i;
  assign pop              = mem_resp_v_i & mem_resp_ready_o;
  assign outstanding_o    = cnt_q;

  // One-hot response valid toward the head owner
  always_comb begin
    mem_resp_v_o = '0;
    if (mem_resp_v_i & ~empty & ~reset_i) begin
      mem_resp_v_o[head_id] = 1'b1;
    end
  end

  // Next-state for grant lock, round-robin pointer, FIFO pointers and in-flight count
  always_comb begin
    last_d    = last_q;
    lock_v_d  = lock_v_q;
    lock_id_d = lock_id_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;

    if (push) begin
      last_d   = grant_id;
      lock_v_d = 1'b0;
      wptr_d   = (wptr_q == ptr_t'(max_outstanding_p - 1)) ? '0 : wptr_q + 1'b1;
    end else if (mem_cmd_v_o) begin
      lock_v_d  = 1'b1;
      lock_id_d = grant_id;
    end

    if (pop) begin
      rptr_d = (rptr_q == ptr_t'(max_outstanding_p - 1)) ? '0 : rptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset makes requester 0 the first winner
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q    <= id_t'(num_req_p - 1);
      lock_v_q  <= 1'b0;
      lock_id_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      last_q    <= last_d;
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Tag storage holds owner IDs; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem_q[wptr_q] <= grant_id;
    end
  end

`ifndef SYNTHESIS
  // Protocol checks on the environment and internal count bounds
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_cmd_yumi_i && !mem_cmd_v_o));
      assert (!(push && !pop && full));
      assert (!(pop && !push && empty));
      assert (!(mem_resp_v_i && empty));
      assert (!(lock_v_q && !mem_cmd_v_i[lock_id_q]));
    end
  end
`endif

endmodule
